// File: rtl/music_player.sv
// Sheet-driven tone sequencer: steps through a combinational music ROM and
// renders each note as a square wave for its programmed number of duration units.
module music_player #(
  parameter int ADDR_W      = 2,
  parameter int TICK_CYCLES = 12_500_000,
  parameter int NOTE_W      = 20,
  parameter int DUR_W       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] number,
  input  logic [NOTE_W-1:0] note,
  input  logic [DUR_W-1:0]  duration,
  input  logic              done,
  output logic              speaker,
  output logic              playing,
  output logic              finished
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_PLAY    = 3'd2,
    S_ADVANCE = 3'd3,
    S_FINISH  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  number_q, number_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic [NOTE_W-1:0]  tone_q, tone_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [DUR_W-1:0]   unit_q, unit_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic               speaker_q, speaker_d;
  logic               playing_q, finished_q;

  // Next-state and counter update; stop overrides every transition out of a busy state.
  always_comb begin
    state_d  = state_q;
    number_d = number_q;
    note_d   = note_q;
    dur_d    = dur_q;
    tone_d   = tone_q;
    tick_d   = tick_q;
    unit_d   = unit_q;
    if (stop && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      number_d = ADDR_W'(0);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            state_d  = S_LOAD;
            number_d = ADDR_W'(0);
          end else begin
            state_d  = S_IDLE;
          end
        end
        S_LOAD: begin
          note_d = note;
          dur_d  = duration;
          tone_d = NOTE_W'(0);
          tick_d = TICK_W'(0);
          unit_d = DUR_W'(0);
          if (done) begin
            state_d = S_FINISH;
          end else if (duration == DUR_W'(0)) begin
            state_d = S_ADVANCE;
          end else begin
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if ((note_q <= NOTE_W'(1)) || (tone_q == note_q - NOTE_W'(1))) begin
            tone_d = NOTE_W'(0);
          end else begin
            tone_d = tone_q + NOTE_W'(1);
          end
          if (tick_q == TICK_LAST) begin
            tick_d = TICK_W'(0);
            unit_d = unit_q + DUR_W'(1);
            if (unit_q == dur_q - DUR_W'(1)) begin
              state_d = S_ADVANCE;
            end else begin
              state_d = S_PLAY;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        S_ADVANCE: begin
          number_d = number_q + ADDR_W'(1);
          state_d  = S_LOAD;
        end
        S_FINISH: begin
          number_d = ADDR_W'(0);
          state_d  = S_IDLE;
        end
        default: begin
          number_d = ADDR_W'(0);
          state_d  = S_IDLE;
        end
      endcase
    end
    // Speaker is computed from next-cycle values so it is aligned with the PLAY cycle it belongs to.
    speaker_d = (state_d == S_PLAY) && (note_d > NOTE_W'(1)) && (tone_d < (note_d >> 1));
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      number_q   <= ADDR_W'(0);
      note_q     <= NOTE_W'(0);
      dur_q      <= DUR_W'(0);
      tone_q     <= NOTE_W'(0);
      tick_q     <= TICK_W'(0);
      unit_q     <= DUR_W'(0);
      speaker_q  <= 1'b0;
      playing_q  <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      number_q   <= number_d;
      note_q     <= note_d;
      dur_q      <= dur_d;
      tone_q     <= tone_d;
      tick_q     <= tick_d;
      unit_q     <= unit_d;
      speaker_q  <= speaker_d;
      playing_q  <= (state_d != S_IDLE);
      finished_q <= (state_d == S_FINISH);
    end
  end

  assign number   = number_q;
  assign speaker  = speaker_q;
  assign playing  = playing_q;
  assign finished = finished_q;

endmodule

// File: doc/music_player.md
Name: music_player

Overview:
- Sequencer that reads the combinational music-sheet ROM and plays it.
- Drives the step index to the sheet and samples the returned note period, duration and done flag.
- Generates a square-wave speaker output for each note for the required length, then advances to the next step.
- Sits between the sheet ROM and the board speaker pin; one clock domain (50 MHz system clock).

Parameters:
- ADDR_W, 2, width of the step index driven to the sheet.
- TICK_CYCLES, 12_500_000, clock cycles per duration unit (0.25 s at 50 MHz; QUARTER=2 units = 0.5 s).
- NOTE_W, 20, width of the note period (full tone period in clock cycles).
- DUR_W, 5, width of the duration field.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; begins playback from step 0 when idle.
- stop  in  1  level; aborts playback.
- number  out  ADDR_W  step index presented to the sheet.
- note  in  NOTE_W  tone period in clocks; a value ≤ 1 is a rest (SP).
- duration  in  DUR_W  note length in units of TICK_CYCLES.
- done  in  1  sheet end marker for the current step.
- speaker  out  1  square-wave tone output.
- playing  out  1  high in every state other than IDLE.
- finished  out  1  one-cycle pulse when the done marker is reached.

Behaviour:
- Reset (async, any state): state=IDLE; number=0; speaker=0; playing=0; finished=0; all counters and latches 0.
- State IDLE:
  - start=1 → LOAD, number=0.
  - Otherwise remain in IDLE.
  - speaker=0.
- State LOAD (1 cycle): sheet outputs settle combinationally from number; note, duration and done are latched at the end of the cycle (note_q, dur_q).
  - done=1 → FINISH.
  - else duration=0 → ADVANCE (zero-length step, no sound).
  - else → PLAY, with tone_cnt=0, tick_cnt=0, unit_cnt=0.
- State PLAY:
  - tone_cnt counts 0..note_q-1 and wraps.
  - speaker (registered) = 1 when tone_cnt < note_q>>1, else 0.
  - note_q ≤ 1 forces speaker=0 (rest).
  - tick_cnt counts 0..TICK_CYCLES-1. On wrap, unit_cnt increments.
  - When tick_cnt=TICK_CYCLES-1 and unit_cnt=dur_q-1 → ADVANCE.
  - PLAY lasts exactly dur_q*TICK_CYCLES cycles.
- State ADVANCE (1 cycle):
  - speaker=0.
  - number=number+1, wrapping modulo 2^ADDR_W; a sheet without a done marker loops forever.
  - → LOAD.
- State FINISH (1 cycle):
  - finished=1, speaker=0, number=0 → IDLE.
- stop=1 in any non-IDLE state → IDLE next cycle; speaker=0, number=0, finished not asserted. stop has priority over every other transition.
- start is ignored outside IDLE. start and stop asserted together in IDLE → stop wins, stay in IDLE.
- Per-note overhead: LOAD + ADVANCE add 2 cycles between notes. Latency from start to the first PLAY cycle is 2 cycles.
- Odd note periods: the high phase is floor(note/2) cycles and the low phase is the remainder.
- note and duration are sampled only in LOAD; changes on the sheet inputs during PLAY have no effect.
- Counter widths: tone_cnt is NOTE_W bits; tick_cnt is ceil(log2(TICK_CYCLES)) bits; unit_cnt is DUR_W bits. No overflow is possible under these rules.

Test Plan:
1. Setup: TICK_CYCLES=4; sheet = {0: note=8, dur=2; 1: note=1, dur=2; 2: note=8, dur=2; 3: done}.
   - Stimulus: pulse start.
   - Expected: number sequence 0,1,2,3; step 0 gives 8 cycles of speaker pattern 1111 0000; step 1 is silent for 8 cycles; step 2 repeats the step-0 pattern; finished pulses exactly once, then playing=0.
2. Assert reset for 1 cycle mid-PLAY on step 2 → all outputs 0 asynchronously (before the next edge); state IDLE; a subsequent start replays from number=0.
3. Assert stop during step 1 → next cycle playing=0, speaker=0, number=0; no finished pulse.
4. Sheet step with dur=0 and note=8 → no speaker activity; LOAD goes directly to ADVANCE (2 cycles); number increments.
5. Sheet with no done marker → number wraps 3→0 and playback continues; playing stays 1.
6. Odd note=5, dur=1, TICK_CYCLES=10 → speaker pattern 11000 11000; start pulsed during PLAY has no effect.
